d_flip_flop_sync_reset: RTL and testbench

- Single-clock, edge-triggered D-type storage element with a synchronous, active-high reset.
- Captures `D` on every rising edge of `clk` and presents it on `Q` until the next rising edge.
- Used as the basic registered-bit primitive in sequential datapaths.
- Width and reset value are parameterised; the defaults give a 1-bit flop that resets to 0.

---
 rtl/d_flip_flop_sync_reset.sv | 34 +++
 tb/tb_d_flip_flop_sync_reset.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/d_flip_flop_sync_reset.sv
// d_flip_flop_sync_reset: WIDTH-bit D-type storage register with a synchronous,
// active-high reset. Used as the basic registered-bit primitive in datapaths.
//
// Parameters:
//   WIDTH       - bit width of D and Q (1 or more)
//   RESET_VALUE - value loaded into Q on a rising edge with reset = 1
//
// Ports:
//   clk   - clock; all state changes occur on its rising edge only
//   reset - synchronous active-high reset, sampled on the rising edge of clk
//   D     - data input, sampled on the rising edge of clk
//   Q     - registered output, driven directly from the storage register

module d_flip_flop_sync_reset #(
    parameter int unsigned            WIDTH       = 1,
    parameter logic [WIDTH-1:0]       RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    // Single storage register; reset is only a data-path mux ahead of it,
    // so it takes effect at a clock edge and overrides D at that edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            Q <= RESET_VALUE;
        end else begin
            Q <= D;
        end
    end

endmodule

// File: tb/tb_d_flip_flop_sync_reset.sv
// Testbench for d_flip_flop_sync_reset: a 1-bit default instance and an 8-bit
// instance with a non-zero reset value, driven on the falling edge, checked
// one time unit after each rising edge and again between edges.

module tb_d_flip_flop_sync_reset;

    localparam logic [7:0] RV8 = 8'hA5;

    logic       clk;
    logic       reset1;
    logic [0:0] d1;
    logic [0:0] q1;
    logic       reset8;
    logic [7:0] d8;
    logic [7:0] q8;

    int checks;
    int errors;

    // Reference model: history of what was presented at every rising edge.
    typedef struct {
        logic       r;
        logic [7:0] d;
    } sample_t;

    sample_t hist1[$];
    sample_t hist8[$];

    d_flip_flop_sync_reset dut1 (
        .clk   (clk),
        .reset (reset1),
        .D     (d1),
        .Q     (q1)
    );

    d_flip_flop_sync_reset #(
        .WIDTH       (8),
        .RESET_VALUE (RV8)
    ) dut8 (
        .clk   (clk),
        .reset (reset8),
        .D     (d8),
        .Q     (q8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Q after an edge: reset value if reset was high at that edge, else the D seen there.
    function automatic logic [7:0] model_q(input sample_t s, input logic [7:0] rv);
        return s.r ? rv : s.d;
    endfunction

    // Drive one cycle from the falling edge. With gl set, D first takes the
    // complement of its final value, so a mid-cycle glitch must not be captured.
    task automatic step(input logic r1, input logic dv1, input logic r8, input logic [7:0] dv8,
                        input logic gl);
        if (gl) begin
            d1 = ~dv1;
            d8 = ~dv8;
            reset1 = ~r1;
            reset8 = ~r8;
            #1;
        end
        reset1 = r1;
        d1     = dv1;
        reset8 = r8;
        d8     = dv8;
        #1;
        // Between edges Q must still hold the value from the previous edge.
        if (hist1.size() > 0)
            check_eq("hold1", {7'b0, q1}, model_q(hist1[$], 8'h00));
        if (hist8.size() > 0)
            check_eq("hold8", q8, model_q(hist8[$], RV8));
        @(posedge clk);
        hist1.push_back('{r: reset1, d: {7'b0, d1}});
        hist8.push_back('{r: reset8, d: d8});
        #1;
        check_eq("q1", {7'b0, q1}, model_q(hist1[$], 8'h00));
        check_eq("q8", q8, model_q(hist8[$], RV8));
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset1 = 1'b0;
        d1     = 1'b0;
        reset8 = 1'b0;
        d8     = 8'h00;

        // Directed sequence (starts at t0, edges at 5, 15, ...).
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);   // t0:  Q1=0
        step(1'b0, 1'b1, 1'b0, 8'h3C, 1'b0);   // t10: Q1=1, Q8=3C
        step(1'b0, 1'b0, 1'b1, 8'h3C, 1'b0);   // t20: Q1=0, Q8=A5
        step(1'b1, 1'b0, 1'b0, 8'hFF, 1'b0);   // t30: reset1, Q8=FF
        step(1'b0, 1'b0, 1'b0, 8'hFF, 1'b0);   // t40: release
        check_eq("dir_q8_ff", q8, 8'hFF);
        step(1'b0, 1'b1, 1'b0, 8'h12, 1'b0);   // t50..t80 toggle
        check_eq("dir_t55", {7'b0, q1}, 8'h01);
        step(1'b0, 1'b0, 1'b0, 8'h34, 1'b0);
        check_eq("dir_t65", {7'b0, q1}, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'h56, 1'b0);
        check_eq("dir_t75", {7'b0, q1}, 8'h01);
        step(1'b0, 1'b0, 1'b0, 8'h78, 1'b0);
        check_eq("dir_t85", {7'b0, q1}, 8'h00);
        // Reset priority over D=1, then resume.
        step(1'b1, 1'b1, 1'b1, 8'hFF, 1'b0);
        check_eq("prio1", {7'b0, q1}, 8'h00);
        check_eq("prio8", q8, 8'hA5);
        step(1'b0, 1'b1, 1'b0, 8'h0F, 1'b0);
        check_eq("resume1", {7'b0, q1}, 8'h01);
        check_eq("resume8", q8, 8'h0F);
        // Reset held several cycles.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b1, 8'hC3, 1'b0);
            check_eq("held8", q8, 8'hA5);
        end
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        // Glitch on D (and reset) between edges must not be captured.
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        check_eq("glitch1", {7'b0, q1}, 8'h00);
        check_eq("glitch8", q8, 8'h00);

        // Randomised phase.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 7) == 0), 1'($urandom), ($urandom_range(0, 7) == 0),
                 8'($urandom), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
